// File: rtl/dmem_req_ctrl_pkg.sv
// Shared encodings for the MEM-stage data-memory request controller:
// load/store type codes, bus size codes, FSM states and the latched request record.
package dmem_req_ctrl_pkg;

  localparam logic [3:0] MR_LB  = 4'b1001;
  localparam logic [3:0] MR_LBU = 4'b0001;
  localparam logic [3:0] MR_LH  = 4'b1011;
  localparam logic [3:0] MR_LHU = 4'b0011;
  localparam logic [3:0] MR_LW  = 4'b1111;

  localparam logic [3:0] MW_SB  = 4'b0001;
  localparam logic [3:0] MW_SH  = 4'b0011;
  localparam logic [3:0] MW_SW  = 4'b1111;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Request attributes held stable while the bus has not yet accepted the address
  typedef struct packed {
    logic        wr;
    logic        load;
    logic [1:0]  size;
    logic [31:0] wdata;
  } req_t;

  function automatic logic is_load(input logic [3:0] mtr);
    case (mtr)
      MR_LB, MR_LBU, MR_LH, MR_LHU, MR_LW: is_load = 1'b1;
      default:                             is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] mw);
    case (mw)
      MW_SB, MW_SH, MW_SW: is_store = 1'b1;
      default:             is_store = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_req_ctrl_store_align.sv
// Combinational access decode: bus size, lane-replicated store data and
// address-alignment errors for the MEM-stage load/store.
module dmem_req_ctrl_store_align
  import dmem_req_ctrl_pkg::*;
(
  input  logic [3:0]  memwrite,
  input  logic [3:0]  memtoreg,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] writedata,
  output logic [1:0]  data_size,
  output logic [31:0] data_wdata,
  output logic        adel,
  output logic        ades
);

  // Stores take precedence; otherwise the load type selects size and alignment rule
  always_comb begin
    data_size  = SIZE_WORD;
    data_wdata = writedata;
    adel       = 1'b0;
    ades       = 1'b0;
    case (memwrite)
      MW_SB: begin
        data_size  = SIZE_BYTE;
        data_wdata = {4{writedata[7:0]}};
      end
      MW_SH: begin
        data_size  = SIZE_HALF;
        data_wdata = {2{writedata[15:0]}};
        ades       = addr_lo[0];
      end
      MW_SW: begin
        data_size  = SIZE_WORD;
        ades       = |addr_lo;
      end
      default: begin
        case (memtoreg)
          MR_LB, MR_LBU: data_size = SIZE_BYTE;
          MR_LH, MR_LHU: begin
            data_size = SIZE_HALF;
            adel      = addr_lo[0];
          end
          MR_LW: begin
            data_size = SIZE_WORD;
            adel      = |addr_lo;
          end
          default: data_size = SIZE_WORD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/dmem_req_ctrl.sv
// MEM-stage data-memory request controller: one sram-like transaction per load/store,
// pipeline stall until data_ok, and capture of the raw word for the load extender.
module dmem_req_ctrl
  import dmem_req_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_en,
  input  logic [3:0]        memtoreg,
  input  logic [3:0]        memwrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] writedata,
  input  logic              flush,
  input  logic              mem_advance,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] readdata,
  output logic [1:0]        lbshift,
  output logic              stall,
  output logic              adel,
  output logic              ades
);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic              discard_r;
  req_t              req_r;
  logic [ADDR_W-1:0] addr_r;
  logic              load_s;
  logic              store_s;
  logic              adel_raw_s;
  logic              ades_raw_s;
  logic              issue_s;
  logic              resp_s;
  logic [1:0]        size_s;
  logic [31:0]       wdata_s;

  dmem_req_ctrl_store_align u_align (
    .memwrite   (memwrite),
    .memtoreg   (memtoreg),
    .addr_lo    (addr[1:0]),
    .writedata  (writedata),
    .data_size  (size_s),
    .data_wdata (wdata_s),
    .adel       (adel_raw_s),
    .ades       (ades_raw_s)
  );

  assign load_s  = is_load(memtoreg);
  assign store_s = is_store(memwrite);
  assign adel    = mem_en & adel_raw_s;
  assign ades    = mem_en & ades_raw_s;
  assign issue_s = (state_r == S_IDLE) & mem_en & (load_s | store_s)
                   & ~adel & ~ades & ~flush;
  assign resp_s  = (state_r == S_WAIT) & data_data_ok;

  // Bus-side drive: live MEM inputs in IDLE, latched copies once a request is pending
  always_comb begin
    data_req = issue_s | (state_r == S_REQ);
    stall    = (issue_s | (state_r == S_REQ) | ((state_r == S_WAIT) & ~data_data_ok))
               & ~discard_r;
    if (state_r == S_IDLE) begin
      data_wr    = store_s;
      data_size  = size_s;
      data_addr  = addr;
      data_wdata = wdata_s;
    end else begin
      data_wr    = req_r.wr;
      data_size  = req_r.size;
      data_addr  = addr_r;
      data_wdata = req_r.wdata;
    end
  end

  // Next-state logic; a flushed transaction skips DONE once its data_ok arrives
  always_comb begin
    case (state_r)
      S_IDLE: begin
        if (issue_s) state_nxt_s = data_addr_ok ? S_WAIT : S_REQ;
        else         state_nxt_s = S_IDLE;
      end
      S_REQ: begin
        if (data_addr_ok) state_nxt_s = S_WAIT;
        else              state_nxt_s = S_REQ;
      end
      S_WAIT: begin
        if (data_data_ok) state_nxt_s = (discard_r | flush) ? S_IDLE : S_DONE;
        else              state_nxt_s = S_WAIT;
      end
      S_DONE: begin
        if (mem_advance | flush) state_nxt_s = S_IDLE;
        else                     state_nxt_s = S_DONE;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, request latch, discard flag and load-result capture
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= S_IDLE;
      discard_r <= 1'b0;
      req_r     <= '0;
      addr_r    <= '0;
      readdata  <= '0;
      lbshift   <= 2'b00;
    end else begin
      state_r <= state_nxt_s;
      if (issue_s) begin
        req_r.wr    <= store_s;
        req_r.load  <= load_s & ~store_s;
        req_r.size  <= size_s;
        req_r.wdata <= wdata_s;
        addr_r      <= addr;
      end
      if (resp_s) begin
        discard_r <= 1'b0;
      end else if (((state_r == S_REQ) | (state_r == S_WAIT)) & flush) begin
        discard_r <= 1'b1;
      end
      if (resp_s & ~discard_r & ~flush) begin
        if (req_r.load) begin
          readdata <= data_rdata;
        end
        lbshift <= addr_r[1:0];
      end
    end
  end

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Directed bench for dmem_req_ctrl: a table of single-cycle IDLE decode vectors
// followed by hand-written multi-cycle bus transactions.
module tb_dmem_req_ctrl;

  logic        clk;
  logic        resetn;
  logic        mem_en;
  logic [3:0]  memtoreg;
  logic [3:0]  memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic        flush;
  logic        mem_advance;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] readdata;
  logic [1:0]  lbshift;
  logic        stall;
  logic        adel;
  logic        ades;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_req_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .mem_en       (mem_en),
    .memtoreg     (memtoreg),
    .memwrite     (memwrite),
    .addr         (addr),
    .writedata    (writedata),
    .flush        (flush),
    .mem_advance  (mem_advance),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .readdata     (readdata),
    .lbshift      (lbshift),
    .stall        (stall),
    .adel         (adel),
    .ades         (ades)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  mtr;
    logic [3:0]  mw;
    logic [31:0] a;
    logic [31:0] wd;
    logic        fl;
    logic        req;
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] wdata;
    logic        el;
    logic        es;
    logic        stl;
    logic        chk_sz;
    logic        chk_wd;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic finish_txn();
    mem_advance = 1'b1;
    mem_en      = 1'b0;
    tick();
    mem_advance = 1'b0;
  endtask

  initial begin
    // en mtr mw addr wd fl | req wr sz wdata adel ades stall chk_sz chk_wd
    vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 32'h100, 32'h0,        1'b0, 1'b1, 1'b0, 2'd2, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 4'b1001, 4'b0000, 32'h103, 32'h0,        1'b0, 1'b1, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 4'b0011, 4'b0000, 32'h102, 32'h0,        1'b0, 1'b1, 1'b0, 2'd1, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 4'b1011, 4'b0000, 32'h101, 32'h0,        1'b0, 1'b0, 1'b0, 2'd1, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 4'b1111, 4'b0000, 32'h101, 32'h0,        1'b0, 1'b0, 1'b0, 2'd2, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 4'b1111, 4'b0000, 32'h102, 32'h0,        1'b0, 1'b0, 1'b0, 2'd2, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 4'b0000, 4'b0001, 32'h003, 32'h12345678, 1'b0, 1'b1, 1'b1, 2'd0, 32'h78787878, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 4'b0000, 4'b0011, 32'h202, 32'h1234ABCD, 1'b0, 1'b1, 1'b1, 2'd1, 32'hABCDABCD, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 4'b0000, 4'b1111, 32'h200, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1, 2'd2, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 4'b0000, 4'b0011, 32'h203, 32'h1234ABCD, 1'b0, 1'b0, 1'b1, 2'd1, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 4'b0000, 4'b1111, 32'h202, 32'h55AA55AA, 1'b0, 1'b0, 1'b1, 2'd2, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 4'b1111, 4'b0000, 32'h100, 32'h0,        1'b1, 1'b0, 1'b0, 2'd2, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 4'b1111, 4'b0000, 32'h100, 32'h0,        1'b0, 1'b0, 1'b0, 2'd2, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 4'b0000, 4'b0000, 32'h100, 32'h0,        1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 4'b0101, 4'b0000, 32'h100, 32'h0,        1'b0, 1'b0, 1'b0, 2'd0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    resetn = 1'b0; mem_en = 1'b0; memtoreg = 4'b0000; memwrite = 4'b0000;
    addr = 32'h0; writedata = 32'h0; flush = 1'b0; mem_advance = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;

    // reset state
    #12;
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_lbshift", {30'd0, lbshift}, 32'h0);
    chk("rst_stall", {31'd0, stall}, 32'h0);
    chk("rst_req", {31'd0, data_req}, 32'h0);
    resetn = 1'b1;

    // IDLE-state decode table; mem_en dropped before each rising edge
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      mem_en = vecs[i].en; memtoreg = vecs[i].mtr; memwrite = vecs[i].mw;
      addr = vecs[i].a; writedata = vecs[i].wd; flush = vecs[i].fl;
      #1;
      chk($sformatf("v%0d_req", i),   {31'd0, data_req}, {31'd0, vecs[i].req});
      chk($sformatf("v%0d_wr", i),    {31'd0, data_wr},  {31'd0, vecs[i].wr});
      chk($sformatf("v%0d_adel", i),  {31'd0, adel},     {31'd0, vecs[i].el});
      chk($sformatf("v%0d_ades", i),  {31'd0, ades},     {31'd0, vecs[i].es});
      chk($sformatf("v%0d_stall", i), {31'd0, stall},    {31'd0, vecs[i].stl});
      chk($sformatf("v%0d_addr", i),  data_addr,         vecs[i].a);
      if (vecs[i].chk_sz) chk($sformatf("v%0d_size", i), {30'd0, data_size}, {30'd0, vecs[i].sz});
      if (vecs[i].chk_wd) chk($sformatf("v%0d_wdata", i), data_wdata, vecs[i].wdata);
      mem_en = 1'b0; flush = 1'b0;
    end
    memtoreg = 4'b0000; memwrite = 4'b0000;
    tick();

    // LW 0x100, addr_ok in the issue cycle, data_ok two cycles after issue
    mem_en = 1'b1; memtoreg = 4'b1111; addr = 32'h100; data_addr_ok = 1'b1;
    #1;
    chk("lw_c0_stall", {31'd0, stall}, 32'h1);
    chk("lw_c0_req", {31'd0, data_req}, 32'h1);
    tick();
    data_addr_ok = 1'b0;
    #1;
    chk("lw_c1_stall", {31'd0, stall}, 32'h1);
    chk("lw_c1_req", {31'd0, data_req}, 32'h0);
    tick();
    data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
    #1;
    chk("lw_c2_stall", {31'd0, stall}, 32'h0);
    tick();
    data_data_ok = 1'b0;
    #1;
    chk("lw_readdata", readdata, 32'hDEADBEEF);
    chk("lw_lbshift", {30'd0, lbshift}, 32'h0);
    chk("lw_done_stall", {31'd0, stall}, 32'h0);
    finish_txn();

    // LB 0x103 with addr_ok delayed three cycles; MEM address wiggles meanwhile
    mem_en = 1'b1; memtoreg = 4'b1001; addr = 32'h103;
    for (int k = 0; k < 4; k++) begin
      data_addr_ok = (k == 3);
      #1;
      chk($sformatf("lb_c%0d_req", k), {31'd0, data_req}, 32'h1);
      chk($sformatf("lb_c%0d_addr", k), data_addr, 32'h103);
      chk($sformatf("lb_c%0d_size", k), {30'd0, data_size}, 32'h0);
      chk($sformatf("lb_c%0d_stall", k), {31'd0, stall}, 32'h1);
      tick();
      addr = 32'hFFC;
    end
    data_addr_ok = 1'b0;
    #1;
    chk("lb_wait_req", {31'd0, data_req}, 32'h0);
    chk("lb_wait_stall", {31'd0, stall}, 32'h1);
    tick();
    data_data_ok = 1'b1; data_rdata = 32'h11223380;
    tick();
    data_data_ok = 1'b0;
    #1;
    chk("lb_lbshift", {30'd0, lbshift}, 32'h3);
    chk("lb_readdata", readdata, 32'h11223380);
    finish_txn();

    // SH 0x202: lane-replicated halfword store, stall until data_ok
    mem_en = 1'b1; memtoreg = 4'b0000; memwrite = 4'b0011; addr = 32'h202;
    writedata = 32'h1234ABCD; data_addr_ok = 1'b1;
    #1;
    chk("sh_wr", {31'd0, data_wr}, 32'h1);
    chk("sh_size", {30'd0, data_size}, 32'h1);
    chk("sh_wdata", data_wdata, 32'hABCDABCD);
    chk("sh_c0_stall", {31'd0, stall}, 32'h1);
    tick();
    data_addr_ok = 1'b0;
    #1;
    chk("sh_c1_stall", {31'd0, stall}, 32'h1);
    tick();
    data_data_ok = 1'b1; data_rdata = 32'h99999999;
    #1;
    chk("sh_c2_stall", {31'd0, stall}, 32'h0);
    tick();
    data_data_ok = 1'b0;
    #1;
    chk("sh_readdata_kept", readdata, 32'h11223380);
    chk("sh_lbshift", {30'd0, lbshift}, 32'h2);
    finish_txn();
    memwrite = 4'b0000;

    // flush while waiting for data: response consumed, result discarded
    mem_en = 1'b1; memtoreg = 4'b1111; addr = 32'h104; data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; flush = 1'b1;
    #1;
    chk("fl_flush_cycle_stall", {31'd0, stall}, 32'h1);
    tick();
    flush = 1'b0; mem_en = 1'b0;
    #1;
    chk("fl_after_stall", {31'd0, stall}, 32'h0);
    tick();
    data_data_ok = 1'b1; data_rdata = 32'hBAD0BAD0;
    #1;
    chk("fl_dok_stall", {31'd0, stall}, 32'h0);
    tick();
    data_data_ok = 1'b0;
    mem_en = 1'b1; memtoreg = 4'b1111; addr = 32'h108; data_addr_ok = 1'b1;
    #1;
    chk("fl_readdata_kept", readdata, 32'h11223380);
    chk("fl_next_req", {31'd0, data_req}, 32'h1);
    chk("fl_next_stall", {31'd0, stall}, 32'h1);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0F0F0F0F;
    tick();
    data_data_ok = 1'b0;
    #1;
    chk("fl_next_readdata", readdata, 32'h0F0F0F0F);
    finish_txn();

    // DONE held by mem_advance=0: no re-issue, no stall
    mem_en = 1'b1; memtoreg = 4'b1111; addr = 32'h10C; data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h13579BDF;
    tick();
    data_data_ok = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("hold%0d_req", k), {31'd0, data_req}, 32'h0);
      chk($sformatf("hold%0d_stall", k), {31'd0, stall}, 32'h0);
      tick();
    end
    chk("hold_readdata", readdata, 32'h13579BDF);
    mem_advance = 1'b1;
    tick();
    mem_advance = 1'b0;
    addr = 32'h110;
    #1;
    chk("adv_idle_reissue", {31'd0, data_req}, 32'h1);

    // reset asserted mid-transaction (in WAIT)
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; mem_en = 1'b0; resetn = 1'b0;
    #1;
    chk("rstw_readdata", readdata, 32'h0);
    chk("rstw_lbshift", {30'd0, lbshift}, 32'h0);
    chk("rstw_stall", {31'd0, stall}, 32'h0);
    chk("rstw_req", {31'd0, data_req}, 32'h0);
    #1;
    resetn = 1'b1;
    mem_en = 1'b1; memtoreg = 4'b1111; addr = 32'h114;
    #1;
    chk("rstw_idle_issue", {31'd0, data_req}, 32'h1);
    mem_en = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
